uart_rx: RTL and testbench

8N1 UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of the existing transmitter and consumes the serial line that transmitter drives; the two share CLKS_PER_BIT. It oversamples the asynchronous line with the system clock, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe. Stop-bit errors are flagged separately.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and framing constants.
// The bit-period default is shared with the transmitter so both ends agree.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 105;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_CLEANUP   = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RST_VAL lets callers pick the inactive level of the line being synchronized.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized serial line,
// one-cycle strobes for a good byte or a low stop bit.
//
// state        | meaning
// -------------+--------------------------------------------------------
// RX_IDLE      | line idle, waiting for a low level
// RX_START     | timing to the middle of the start bit, rejects glitches
// RX_DATA      | sampling 8 data bits LSB first, one per bit period
// RX_STOP      | waiting for the middle of the stop bit
// RX_CLEANUP   | one cycle after a good byte, strobe drops
// RX_WAIT_HIGH | after a framing error/break, wait for the line to rise
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]  CLKS_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_sys (i_Clock),
    .rst_b   (i_Rst_L),
    .d       (i_Rx_Serial),
    .q       (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 dv_q, dv_d;
  logic                 err_q, err_d;
  logic                 active_q, active_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;

    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // The detection cycle already counts as the first start-bit clock.
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = CNT_W'(1);
        end
      end

      RX_START: begin
        if (cnt_q == CLKS_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = RX_CLEANUP;
          end else begin
            err_d   = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_CLEANUP: state_d = RX_IDLE;

      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = err_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks per bit: a behavioural transmitter drives the
// line, a scoreboard holds expected bytes and the edge each DV should land on.
module tb_uart_rx;

  localparam int CPB = 8;
  localparam int DV_LAT = 78;  // edge-0 offset (1) plus the 77-edge receive latency

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_L        (rst_n),
    .i_Rx_Serial    (rx_line),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Active    (o_Rx_Active)
  );

  typedef struct {
    logic [7:0] b;
    int         edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   err_cnt = 0;
  int   err_exp = -1;
  int   gap_low = 0;
  int   burst_base = 0;
  bit   burst_on = 0;
  bit   act_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: must be called right after a falling clock edge.
  // It shares the reset with the receiver and idles the line when reset hits.
  task automatic send(input logic [7:0] b, input logic stop, input bit good);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (good) sb.push_back('{b: b, edge_n: cyc + DV_LAT});
    else if (!stop) err_exp = cyc + DV_LAT;
    for (int i = 0; i < 10; i++) begin
      rx_line = frame[i];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (!rst_n) begin
          rx_line = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  initial forever begin
    exp_t e;
    bit   prev_dv;
    bit   prev_err;
    @(negedge clk);
    if (rst_n) begin
      if (o_Rx_DV) begin
        dv_cnt++;
        check_eq("dv_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("rx_byte", 32'(o_Rx_Byte), 32'(e.b));
          check_eq("dv_edge", cyc, e.edge_n);
        end
        check_eq("dv_width", 32'(prev_dv), 32'd0);
      end
      if (o_Rx_Frame_Err) begin
        err_cnt++;
        check_eq("err_edge", cyc, err_exp);
        check_eq("err_width", 32'(prev_err), 32'd0);
      end
      if (o_Rx_DV || o_Rx_Frame_Err)
        check_eq("strobe_excl", 32'(o_Rx_DV & o_Rx_Frame_Err), 32'd0);
      if (o_Rx_Active) act_seen = 1'b1;
      if (burst_on && dv_cnt > burst_base && dv_cnt < burst_base + 4 && !o_Rx_Active)
        gap_low++;
    end
    prev_dv  = o_Rx_DV;
    prev_err = o_Rx_Frame_Err;
  end

  initial begin
    int base_dv;
    int base_err;
    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_dv",     32'(o_Rx_DV),        32'd0);
    check_eq("rst_byte",   32'(o_Rx_Byte),      32'd0);
    check_eq("rst_err",    32'(o_Rx_Frame_Err), 32'd0);
    check_eq("rst_active", 32'(o_Rx_Active),    32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1);
    wait_drain("a5_drain");
    check_eq("a5_dv_cnt", dv_cnt, 1);
    check_eq("a5_no_err", err_cnt, 0);
    repeat (10) @(negedge clk);

    burst_base = dv_cnt;
    burst_on   = 1'b1;
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    send(8'h55, 1'b1, 1'b1);
    send(8'h80, 1'b1, 1'b1);
    wait_drain("burst_drain");
    burst_on = 1'b0;
    check_eq("burst_dv_cnt", dv_cnt - burst_base, 4);
    // Active low from each DV edge until the next start is accepted: 8 clocks per gap.
    check_eq("burst_gap_low", gap_low, 24);
    repeat (10) @(negedge clk);

    base_dv  = dv_cnt;
    base_err = err_cnt;
    act_seen = 1'b0;
    rx_line  = 1'b0;
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    check_eq("glitch_active", 32'(act_seen), 32'd0);
    check_eq("glitch_dv", dv_cnt - base_dv, 0);
    check_eq("glitch_err", err_cnt - base_err, 0);

    base_dv  = dv_cnt;
    base_err = err_cnt;
    send(8'h3C, 1'b0, 1'b0);
    repeat (50 * CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_eq("brk_err_cnt", err_cnt - base_err, 1);
    check_eq("brk_no_dv", dv_cnt - base_dv, 0);
    check_eq("brk_byte_hold", 32'(o_Rx_Byte), 32'h80);
    send(8'h12, 1'b1, 1'b1);
    wait_drain("post_brk_drain");
    repeat (10) @(negedge clk);

    base_dv  = dv_cnt;
    base_err = err_cnt;
    fork
      send(8'hC3, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + 3) @(negedge clk);
        check_eq("mid_active", 32'(o_Rx_Active), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_dv",     32'(o_Rx_DV),        32'd0);
        check_eq("async_byte",   32'(o_Rx_Byte),      32'd0);
        check_eq("async_err",    32'(o_Rx_Frame_Err), 32'd0);
        check_eq("async_active", 32'(o_Rx_Active),    32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (12 * CPB) @(negedge clk);
    check_eq("rst_frame_dv", dv_cnt - base_dv, 0);
    check_eq("rst_frame_err", err_cnt - base_err, 0);
    send(8'h7E, 1'b1, 1'b1);
    wait_drain("post_rst_drain");
    check_eq("post_rst_dv", dv_cnt - base_dv, 1);

    repeat (10) @(negedge clk);
    check_eq("total_dv", dv_cnt, 7);
    check_eq("total_err", err_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
